// File: rtl/mdu_issue_if.sv
// rtl/mdu_issue_if.sv - EX/MDU handshake bundle for the mdu_issue stage
interface mdu_issue_if;
    logic        ex_valid;
    logic [3:0]  ex_mdop;
    logic [31:0] ex_rs;
    logic [31:0] ex_rt;
    logic        exc_cancel;
    logic        mdu_busy;
    logic        mdu_start;
    logic [2:0]  mdu_op;
    logic [31:0] mdu_a;
    logic [31:0] mdu_b;
    logic        mdu_sel;
    logic        stall_ex;

    modport master (
        output ex_valid, ex_mdop, ex_rs, ex_rt, exc_cancel, mdu_busy,
        input  mdu_start, mdu_op, mdu_a, mdu_b, mdu_sel, stall_ex
    );

    modport slave (
        input  ex_valid, ex_mdop, ex_rs, ex_rt, exc_cancel, mdu_busy,
        output mdu_start, mdu_op, mdu_a, mdu_b, mdu_sel, stall_ex
    );
endinterface

// File: rtl/mdu_issue.sv
// rtl/mdu_issue.sv - HI/LO issue and interlock stage between EX and the multiply/divide unit
module mdu_issue #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input logic        clk,
    input logic        rst,
    mdu_issue_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic        md_req, occupied, accept, issuing;

    always_comb begin
        md_req   = bus.ex_valid && (bus.ex_mdop >= 4'd1) && (bus.ex_mdop <= 4'd8);
        occupied = (state != IDLE) || bus.mdu_busy || (cnt != 4'd0);
        accept   = md_req && !occupied && !bus.exc_cancel && (bus.ex_mdop <= 4'd6);
        issuing  = (state == ISSUE) && !bus.exc_cancel;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (bus.exc_cancel) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (op_q <= 3'd2) begin
                    state_nxt = WAIT;
                    cnt_nxt   = MULT_CNT;
                end else if (op_q <= 3'd4) begin
                    state_nxt = WAIT;
                    cnt_nxt   = DIV_CNT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                // Leave as the count reaches zero so EX is released in that same cycle.
                if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
                if ((cnt_nxt == 4'd0) && !bus.mdu_busy) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                op_q <= bus.ex_mdop[2:0];
                a_q  <= bus.ex_rs;
                b_q  <= bus.ex_rt;
            end
        end
    end

    always_comb begin
        bus.mdu_op    = issuing ? op_q : 3'd0;
        bus.mdu_start = issuing && (op_q <= 3'd4);
        bus.mdu_a     = a_q;
        bus.mdu_b     = b_q;
        bus.mdu_sel   = (bus.ex_mdop == 4'd8);
        bus.stall_ex  = md_req && occupied;
    end
endmodule

// File: tb/tb_mdu_issue.sv
// tb/tb_mdu_issue.sv - scoreboard bench for mdu_issue with a behavioural MDU and issue model
module tb_mdu_issue;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mdu_issue_if bus ();

    mdu_issue #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        start;
        int          due;
    } cmd_t;

    cmd_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    // HI/LO semantics shared by the environment MDU and the reference model.
    function automatic logic [63:0] mdu_calc(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                                             logic [31:0] hi, logic [31:0] lo);
        logic [63:0]        r;
        logic signed [63:0] sa, sb;
        r  = {hi, lo};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            3'd1: r = 64'(sa * sb);
            3'd2: r = {32'd0, a} * {32'd0, b};
            3'd3: if (b != 32'd0) r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            3'd4: if (b != 32'd0) r = {a % b, a / b};
            3'd5: r[31:0]  = a;
            3'd6: r[63:32] = a;
            default: r = {hi, lo};
        endcase
        return r;
    endfunction

    // Environment MDU: busy for LAT-1 cycles after a start, HI/LO updated when it samples a command.
    logic        force_busy = 1'b0;
    int          busy_cnt   = 0;
    logic [31:0] env_hi     = 32'd0;
    logic [31:0] env_lo     = 32'd0;
    assign bus.mdu_busy = force_busy || (busy_cnt != 0);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cnt <= 0;
        end else begin
            if (bus.mdu_start)
                busy_cnt <= (bus.mdu_op <= 3'd2) ? MULT_LAT - 1 : DIV_LAT - 1;
            else if (busy_cnt > 0)
                busy_cnt <= busy_cnt - 1;
            if (bus.mdu_op != 3'd0)
                {env_hi, env_lo} <= mdu_calc(bus.mdu_op, bus.mdu_a, bus.mdu_b, env_hi, env_lo);
        end
    end

    // Reference model: occupancy as a cycle horizon, plus the pending command awaiting its issue cycle.
    int          occ_until = 0;
    logic [31:0] ref_hi    = 32'd0;
    logic [31:0] ref_lo    = 32'd0;
    logic        pend_valid = 1'b0;
    cmd_t        pend;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step(logic v, logic [3:0] op, logic [31:0] rs, logic [31:0] rt, logic cancel);
        logic occ, md_req, exp_stall;
        bus.ex_valid   = v;
        bus.ex_mdop    = op;
        bus.ex_rs      = rs;
        bus.ex_rt      = rt;
        bus.exc_cancel = cancel;
        if (pend_valid && pend.due == cyc) begin
            pend_valid = 1'b0;
            if (cancel) begin
                void'(exp_q.pop_back());
                occ_until = cyc + 1;
            end else begin
                {ref_hi, ref_lo} = mdu_calc(pend.op, pend.a, pend.b, ref_hi, ref_lo);
            end
        end
        @(negedge clk);
        occ       = (cyc < occ_until) || bus.mdu_busy;
        md_req    = v && (op >= 4'd1) && (op <= 4'd8);
        exp_stall = md_req && occ;
        check("stall_ex", 32'(bus.stall_ex), 32'(exp_stall));
        check("mdu_sel", 32'(bus.mdu_sel), 32'(op == 4'd8));
        if (v && (op == 4'd7 || op == 4'd8) && !exp_stall)
            check((op == 4'd8) ? "mfhi_value" : "mflo_value",
                  bus.mdu_sel ? env_hi : env_lo, (op == 4'd8) ? ref_hi : ref_lo);
        if (md_req && !occ && !cancel && op <= 4'd6) begin
            pend.op    = op[2:0];
            pend.a     = rs;
            pend.b     = rt;
            pend.start = (op <= 4'd4);
            pend.due   = cyc + 1;
            pend_valid = 1'b1;
            exp_q.push_back(pend);
            occ_until  = cyc + ((op <= 4'd2) ? MULT_LAT + 2 : (op <= 4'd4) ? DIV_LAT + 2 : 2);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Monitor: every command the DUT presents must match the oldest expected one, in its cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.mdu_op != 3'd0 || bus.mdu_start) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_cmd cycle=%0d actual op=%0d start=%0d required none",
                             cyc, bus.mdu_op, bus.mdu_start);
                end else begin
                    cmd_t e;
                    e = exp_q.pop_front();
                    check("cmd_op", 32'(bus.mdu_op), 32'(e.op));
                    check("cmd_start", 32'(bus.mdu_start), 32'(e.start));
                    check("cmd_a", bus.mdu_a, e.a);
                    check("cmd_b", bus.mdu_b, e.b);
                    check("cmd_cycle", 32'(cyc), 32'(e.due));
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_cmd cycle=%0d actual none required op=%0d", cyc, exp_q[0].op);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [3:0]  r_op;
        logic [31:0] r_rs, r_rt;
        bus.ex_valid   = 1'b0;
        bus.ex_mdop    = 4'd0;
        bus.ex_rs      = 32'd0;
        bus.ex_rt      = 32'd0;
        bus.exc_cancel = 1'b0;
        #2;
        check("reset_op", 32'(bus.mdu_op), 32'd0);
        check("reset_start", 32'(bus.mdu_start), 32'd0);
        check("reset_a", bus.mdu_a, 32'd0);
        check("reset_b", bus.mdu_b, 32'd0);
        check("reset_stall", 32'(bus.stall_ex), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // mult 3 * -2, then read HI and LO once released
        step(1'b1, 4'd1, 32'h0000_0003, 32'hFFFF_FFFE, 1'b0);
        repeat (7) step(1'b1, 4'd8, 32'd0, 32'd0, 1'b0);
        step(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
        check("mult_hi", env_hi, 32'hFFFF_FFFF);
        check("mult_lo", env_lo, 32'hFFFF_FFFA);

        // divu followed immediately by mfhi
        step(1'b1, 4'd4, 32'd100, 32'd7, 1'b0);
        repeat (12) step(1'b1, 4'd8, 32'd0, 32'd0, 1'b0);
        check("divu_hi", env_hi, 32'd2);

        // mtlo then mflo
        step(1'b1, 4'd5, 32'h1234_5678, 32'd0, 1'b0);
        repeat (2) step(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
        check("mtlo_lo", env_lo, 32'h1234_5678);

        // div cancelled in its issue cycle, then a mult right after
        step(1'b1, 4'd3, 32'd50, 32'd5, 1'b0);
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        step(1'b1, 4'd1, 32'd7, 32'd9, 1'b0);
        // non-MDU traffic while waiting
        step(1'b1, 4'd0, 32'd1, 32'd2, 1'b0);
        step(1'b1, 4'd12, 32'd1, 32'd2, 1'b0);
        step(1'b1, 4'd15, 32'd1, 32'd2, 1'b1);
        repeat (6) step(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
        check("cancel_then_mult_lo", env_lo, 32'd63);

        // reset while waiting on a div with cnt at 7
        step(1'b1, 4'd3, 32'd1000, 32'd3, 1'b0);
        repeat (4) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        bus.ex_valid = 1'b1;
        bus.ex_mdop  = 4'd1;
        #2 rst = 1'b0;
        #1;
        check("midwait_reset_op", 32'(bus.mdu_op), 32'd0);
        check("midwait_reset_start", 32'(bus.mdu_start), 32'd0);
        check("midwait_reset_a", bus.mdu_a, 32'd0);
        check("midwait_reset_b", bus.mdu_b, 32'd0);
        check("midwait_reset_stall", 32'(bus.stall_ex), 32'd0);
        exp_q.delete();
        pend_valid = 1'b0;
        occ_until  = 0;
        bus.ex_valid = 1'b0;
        bus.ex_mdop  = 4'd0;
        @(posedge clk);
        cyc++;
        #1 rst = 1'b1;
        step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        force_busy = 1'b1;
        step(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
        step(1'b1, 4'd1, 32'd4, 32'd4, 1'b0);
        force_busy = 1'b0;
        repeat (4) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);

        // randomized traffic
        repeat (1500) begin
            r_op = 4'($urandom_range(0, 15));
            r_rs = $urandom;
            r_rt = $urandom;
            if ((r_op == 4'd3 || r_op == 4'd4) && r_rt == 32'd0) r_rt = 32'd1;
            if (r_op == 4'd3 && r_rs == 32'h8000_0000 && r_rt == 32'hFFFF_FFFF) r_rt = 32'd1;
            step(($urandom % 4) != 0, r_op, r_rs, r_rt, ($urandom % 8) == 0);
        end
        repeat (15) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
